// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: counter width and FSM states.
package count_seq_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_sequencer_counter4.sv
// counter4: 4-bit up counter with synchronous clear (priority) and enable,
// asynchronous active-high reset.
module counter4
    import count_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (enable) begin
            q_d = q_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: runs a job of `reps` passes over 0..limit, then pulses done.
// Optional feature macro: COUNT_SEQUENCER_PAUSE_EN adds a `pause` input that
// freezes the RUN state (count, passes remaining, state) and masks tick.
module count_sequencer
    import count_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] reps,
`ifdef COUNT_SEQUENCER_PAUSE_EN
    input  logic             pause,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] reps_left
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [CNT_W-1:0] reps_left_q, reps_left_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             run_adv;
    logic             at_limit;

    // RUN may advance on this edge unless held by pause.
`ifdef COUNT_SEQUENCER_PAUSE_EN
    assign run_adv = ~pause;
`else
    assign run_adv = 1'b1;
`endif

    assign at_limit = (cnt == limit_q);

    counter4 u_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .q      (cnt)
    );

    // Next-state, job latches and counter controls.
    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        reps_d      = reps_q;
        reps_left_d = reps_left_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A zero-pass request is dropped without touching any state.
                if (start && (reps != '0)) begin
                    limit_d     = limit;
                    reps_d      = reps;
                    reps_left_d = reps;
                    cnt_clr     = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (run_adv) begin
                    if (!at_limit) begin
                        cnt_en = 1'b1;
                    end else if (reps_left_q > {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        cnt_clr     = 1'b1;
                        reps_left_d = reps_left_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        // Last pass: cnt holds at limit through DONE.
                        reps_left_d = '0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and job registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            limit_q     <= '0;
            reps_q      <= '0;
            reps_left_q <= '0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            reps_q      <= reps_d;
            reps_left_q <= reps_left_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign tick      = busy && at_limit && run_adv;
    assign reps_left = reps_left_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: per-scenario tasks checked against a pass/count model.
module tb_count_sequencer;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [3:0] limit;
    logic [3:0] reps;
`ifdef COUNT_SEQUENCER_PAUSE_EN
    logic       pause;
`endif
    logic [3:0] cnt;
    logic       tick;
    logic       busy;
    logic       done;
    logic [3:0] reps_left;

    int checks;
    int errors;

    count_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .limit     (limit),
        .reps      (reps),
`ifdef COUNT_SEQUENCER_PAUSE_EN
        .pause     (pause),
`endif
        .cnt       (cnt),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .reps_left (reps_left)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Runs one job from a negedge. The model lists every busy cycle as
    // (pass remaining, count) and expects a done cycle then an idle cycle.
    // With noise set, start/limit/reps are scrambled throughout the job.
    task automatic run_job(input logic [3:0] lim, input logic [3:0] rp,
                           input bit noise, input string name);
        int nbusy;
        int want_busy;
        nbusy = 0;
        want_busy = (int'(lim) + 1) * int'(rp);
        start = 1'b1; limit = lim; reps = rp;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int r = int'(rp); r >= 1; r--) begin
            for (int c = 0; c <= int'(lim); c++) begin
                @(negedge CLK);
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || cnt !== 4'(c) ||
                    reps_left !== 4'(r) || tick !== (c == int'(lim))) begin
                    errors++;
                    $display("FAIL %s run: busy=%b done=%b cnt=%0d tick=%b left=%0d, required busy=1 done=0 cnt=%0d tick=%b left=%0d",
                             name, busy, done, cnt, tick, reps_left, c, (c == int'(lim)), r);
                end
                if (busy === 1'b1) nbusy++;
                if (noise) begin
                    start = 1'($urandom); limit = 4'($urandom); reps = 4'($urandom);
                end
            end
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tick !== 1'b0 || cnt !== lim || reps_left !== 4'd0) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b tick=%b cnt=%0d left=%0d, required 1 0 0 %0d 0",
                     name, done, busy, tick, cnt, reps_left, lim);
        end
        start = 1'b0;
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cnt !== 4'd0 || nbusy != want_busy) begin
            errors++;
            $display("FAIL %s idle: done=%b busy=%b cnt=%0d busy_cycles=%0d, required 0 0 0 %0d",
                     name, done, busy, cnt, nbusy, want_busy);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; limit = 4'd0; reps = 4'd0;
`ifdef COUNT_SEQUENCER_PAUSE_EN
        pause = 1'b0;
`endif
        #3;
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || reps_left !== 4'd0) begin
            errors++;
            $display("FAIL reset: cnt=%0d busy=%b tick=%b done=%b left=%0d, required all 0",
                     cnt, busy, tick, done, reps_left);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic();
        run_job(4'd3, 4'd2, 1'b0, "basic_l3r2");
    endtask

    task automatic test_limit_zero();
        run_job(4'd0, 4'd3, 1'b0, "limit0_r3");
    endtask

    task automatic test_reps_zero();
        start = 1'b1; limit = 4'd6; reps = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || cnt !== 4'd0 || reps_left !== 4'd0) begin
                errors++;
                $display("FAIL reps0: busy=%b done=%b cnt=%0d left=%0d, required 0 0 0 0",
                         busy, done, cnt, reps_left);
            end
        end
        start = 1'b0;
    endtask

    // Re-start and new limit mid-job must not disturb the running job.
    task automatic test_ignore_inputs();
        start = 1'b1; limit = 4'd5; reps = 4'd1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge CLK);
            checks++;
            if (cnt !== 4'(c) || busy !== 1'b1 || tick !== (c == 5)) begin
                errors++;
                $display("FAIL ignore run: cnt=%0d busy=%b tick=%b, required cnt=%0d busy=1 tick=%b",
                         cnt, busy, tick, c, (c == 5));
            end
            if (c == 2) begin start = 1'b1; limit = 4'd2; end
            else        start = 1'b0;
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || cnt !== 4'd5) begin
            errors++;
            $display("FAIL ignore done: done=%b cnt=%0d, required done=1 cnt=5", done, cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore no_second_job: done=%b busy=%b, required 0 0", done, busy);
            end
        end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            logic [3:0] l;
            logic [3:0] r;
            l = 4'($urandom_range(0, 15));
            r = 4'($urandom_range(1, 4));
            run_job(l, r, 1'b1, $sformatf("random%0d_l%0dr%0d", j, l, r));
        end
    endtask

    task automatic test_back_to_back();
        run_job(4'd1, 4'd1, 1'b0, "b2b_a");
        run_job(4'd2, 4'd2, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1; limit = 4'd7; reps = 4'd1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (cnt !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: cnt=%0d busy=%b, required cnt=2 busy=1", cnt, busy);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || reps_left !== 4'd0) begin
            errors++;
            $display("FAIL midrst async: cnt=%0d busy=%b tick=%b done=%b left=%0d, required all 0",
                     cnt, busy, tick, done, reps_left);
        end
        @(negedge CLK);
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst held: cnt=%0d busy=%b done=%b, required 0 0 0", cnt, busy, done);
        end
        RST = 1'b0;
        run_job(4'd4, 4'd2, 1'b0, "after_reset");
    endtask

`ifdef COUNT_SEQUENCER_PAUSE_EN
    task automatic test_pause();
        int nbusy;
        nbusy = 0;
        start = 1'b1; limit = 4'd3; reps = 4'd1; pause = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge CLK);
            if (busy === 1'b1) nbusy++;
            checks++;
            if (cnt !== 4'(c) || tick !== (c == 3)) begin
                errors++;
                $display("FAIL pause run: cnt=%0d tick=%b, required cnt=%0d tick=%b", cnt, tick, c, (c == 3));
            end
        end
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (cnt !== 4'd3 || tick !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL pause hold: cnt=%0d tick=%b busy=%b done=%b, required 3 0 1 0", cnt, tick, busy, done);
            end
            @(negedge CLK);
            if (busy === 1'b1) nbusy++;
        end
        pause = 1'b0;
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || nbusy != 6) begin
            errors++;
            $display("FAIL pause done: done=%b busy_cycles=%0d, required done=1 busy_cycles=6", done, nbusy);
        end
        @(negedge CLK);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_limit_zero();
        test_reps_zero();
        test_ignore_inputs();
        test_back_to_back();
        test_random_jobs();
        test_reset_mid_job();
`ifdef COUNT_SEQUENCER_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Global bound so a stuck DUT still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
